wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arbiter
//  Purpose  : Two-port register-file writeback arbiter. Each requester
//             (0 = ALU writeback, 1 = load/multicycle writeback) owns a
//             single-entry holding slot. Held entries are granted round-robin
//             and issued to the register file through registered write
//             outputs. Writes to the hardwired-zero register are dropped at
//             acceptance.
//  Ports    : clk        - sole clock, rising edge
//             reset      - synchronous, active-high reset
//             req_valid  - per-requester write request            [1:0]
//             req_addr   - per-requester destination address      5 x [1:0]
//             req_data   - per-requester write data               DW x [1:0]
//             req_ready  - per-requester accept indication        [1:0]
//             flush      - discard all held, not-yet-issued requests
//             wr_en      - register-file write enable (registered)
//             wr_sel     - address/data mux select (registered)
//             wr_addr    - register-file write address (registered)
//             wr_data    - register-file write data (registered)
//             busy       - at least one holding slot is occupied
//  Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
    parameter int         DW   = 64,
    parameter logic [4:0] ZREG = 5'd31
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    req_valid,
    input  logic [4:0]    req_addr [1:0],
    input  logic [DW-1:0] req_data [1:0],
    output logic [1:0]    req_ready,
    input  logic          flush,
    output logic          wr_en,
    output logic          wr_sel,
    output logic [4:0]    wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]    held_q,  held_d;
    logic [4:0]    haddr_q [1:0];
    logic [4:0]    haddr_d [1:0];
    logic [DW-1:0] hdata_q [1:0];
    logic [DW-1:0] hdata_d [1:0];
    logic          last_grant_q, last_grant_d;
    logic          wr_en_q,   wr_en_d;
    logic          wr_sel_q,  wr_sel_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [1:0] grant;
    logic [1:0] accept;
    logic       gsel;

    // Grant depends only on held slots and the previous winner, so the
    // ready path never sees the request inputs.
    always_comb begin
        grant = 2'b00;
        case (held_q)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    assign gsel   = grant[1];
    assign accept = req_valid & req_ready;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            held_q       <= 2'b00;
            last_grant_q <= 1'b1;   // port 0 wins the first tie
            wr_en_q      <= 1'b0;
            wr_sel_q     <= 1'b0;
            wr_addr_q    <= 5'd0;
            wr_data_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                haddr_q[i] <= 5'd0;
                hdata_q[i] <= '0;
            end
        end else begin
            held_q       <= held_d;
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_sel_q     <= wr_sel_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            for (int i = 0; i < 2; i++) begin
                haddr_q[i] <= haddr_d[i];
                hdata_q[i] <= hdata_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        held_d       = held_q;
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_sel_d     = wr_sel_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        for (int i = 0; i < 2; i++) begin
            haddr_d[i] = haddr_q[i];
            hdata_d[i] = hdata_q[i];
        end

        if (flush) begin
            // Pending entries are dropped and nothing issues this edge;
            // the round-robin pointer is left where it was.
            held_d = 2'b00;
        end else begin
            if (|grant) begin
                wr_en_d      = 1'b1;
                wr_sel_d     = gsel;
                wr_addr_d    = haddr_q[gsel];
                wr_data_d    = hdata_q[gsel];
                last_grant_d = gsel;
            end
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    held_d[i] = 1'b0;
                end
                // A same-edge acceptance refills a slot being drained, which
                // is what gives a lone requester one write per cycle.
                // Zero-register writes are accepted but never stored.
                if (accept[i] && (req_addr[i] != ZREG)) begin
                    held_d[i]  = 1'b1;
                    haddr_d[i] = req_addr[i];
                    hdata_d[i] = req_data[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready = ~{2{reset}} & ~{2{flush}} & (~held_q | grant);
    assign busy      = |held_q;
    assign wr_en     = wr_en_q;
    assign wr_sel    = wr_sel_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Scoreboard testbench for wb_port_arbiter. Directed scenarios
//             followed by randomized traffic, checked against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int         DW   = 64;
    localparam logic [4:0] ZREG = 5'd31;

    typedef struct packed {
        logic          wen;
        logic          sel;
        logic [4:0]    addr;
        logic [DW-1:0] data;
        logic          busy;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid;
    logic [4:0]    req_addr [1:0];
    logic [DW-1:0] req_data [1:0];
    logic [1:0]    req_ready;
    logic          flush;
    logic          wr_en;
    logic          wr_sel;
    logic [4:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rec_t exp_q[$];

    // Reference model: each requester has at most one pending write; when
    // both are pending the one that did not win last time goes next.
    logic [1:0]    m_pend;
    logic [4:0]    m_paddr [2];
    logic [DW-1:0] m_pdata [2];
    logic          m_last = 1'b1;
    rec_t          m_out;

    wb_port_arbiter #(.DW(DW), .ZREG(ZREG)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Monitor: each edge's expected output state is compared mid-cycle.
    rec_t mon_e;
    rec_t mon_g;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_g = '{wen: wr_en, sel: wr_sel, addr: wr_addr, data: wr_data, busy: busy};
            total++;
            if (mon_g !== mon_e) begin
                bad++;
                $display("FAIL wr_out cyc=%0d got wen=%0b sel=%0b addr=%0d data=%h busy=%0b exp wen=%0b sel=%0b addr=%0d data=%h busy=%0b",
                         cyc, mon_g.wen, mon_g.sel, mon_g.addr, mon_g.data, mon_g.busy,
                         mon_e.wen, mon_e.sel, mon_e.addr, mon_e.data, mon_e.busy);
            end
        end
    end

    // One clock cycle: drive inputs, check ready, advance the model, push
    // the expected post-edge outputs once the edge has happened.
    task automatic step(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic fl, input logic rst);
        int            g;
        logic [1:0]    rdy;
        logic [4:0]    a [2];
        logic [DW-1:0] d [2];
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        req_valid   = v;
        req_addr[0] = a0;
        req_addr[1] = a1;
        req_data[0] = d0;
        req_data[1] = d1;
        flush       = fl;
        reset       = rst;
        #1;

        g = -1;
        if (m_pend === 2'b11)      g = m_last ? 0 : 1;
        else if (m_pend[0] === 1'b1) g = 0;
        else if (m_pend[1] === 1'b1) g = 1;

        rdy = 2'b00;
        if (!rst && !fl) begin
            for (int i = 0; i < 2; i++)
                rdy[i] = (m_pend[i] !== 1'b1) || (g == i);
        end

        total++;
        if (req_ready !== rdy) begin
            bad++;
            $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, rdy);
        end

        if (rst) begin
            m_pend = 2'b00;
            m_out  = '0;
            m_last = 1'b1;
        end else if (fl) begin
            m_pend    = 2'b00;
            m_out.wen = 1'b0;
        end else begin
            if (g >= 0) begin
                m_out.wen  = 1'b1;
                m_out.sel  = g[0];
                m_out.addr = m_paddr[g];
                m_out.data = m_pdata[g];
                m_last     = g[0];
                m_pend[g]  = 1'b0;
            end else begin
                m_out.wen = 1'b0;
            end
            for (int i = 0; i < 2; i++) begin
                if (v[i] && rdy[i] && (a[i] != ZREG)) begin
                    m_pend[i]  = 1'b1;
                    m_paddr[i] = a[i];
                    m_pdata[i] = d[i];
                end
            end
        end
        m_out.busy = |m_pend;

        @(posedge clk);
        #1;
        cyc++;
        exp_q.push_back(m_out);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        req_valid   = 2'b00;
        req_addr[0] = 5'd0;
        req_addr[1] = 5'd0;
        req_data[0] = '0;
        req_data[1] = '0;
        flush       = 1'b0;
        reset       = 1'b1;
        m_pend      = 2'b00;
        m_out       = '0;

        // Reset
        for (int k = 0; k < 3; k++) step(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 1'b1);
        idle(2);

        // Single write from port 0
        step(2'b01, 5'd5, 5'd0, 64'hA5, '0, 1'b0, 1'b0);
        idle(4);

        // Simultaneous requests, then a second tie
        step(2'b11, 5'd3, 5'd7, 64'h33, 64'h77, 1'b0, 1'b0);
        idle(4);
        step(2'b11, 5'd10, 5'd11, 64'h1010, 64'h1111, 1'b0, 1'b0);
        idle(4);

        // Zero-register write is swallowed
        step(2'b10, 5'd0, ZREG, '0, 64'hDEAD, 1'b0, 1'b0);
        idle(3);

        // Both ports streaming for 8 cycles
        for (int k = 0; k < 8; k++)
            step(2'b11, 5'(k), 5'(k + 16), 64'(100 + k), 64'(200 + k), 1'b0, 1'b0);
        idle(4);

        // Lone requester streaming
        for (int k = 0; k < 6; k++)
            step(2'b10, 5'd0, 5'(k + 1), '0, 64'(300 + k), 1'b0, 1'b0);
        idle(3);

        // Flush with both slots held
        step(2'b11, 5'd1, 5'd2, 64'hF1, 64'hF2, 1'b0, 1'b0);
        step(2'b11, 5'd4, 5'd6, 64'hE1, 64'hE2, 1'b1, 1'b0);
        idle(4);

        // Reset with both slots held, then a tie
        step(2'b11, 5'd8, 5'd9, 64'hB1, 64'hB2, 1'b0, 1'b0);
        step(2'b00, 5'd0, 5'd0, '0, '0, 1'b0, 1'b1);
        idle(2);
        step(2'b11, 5'd12, 5'd13, 64'hC1, 64'hC2, 1'b0, 1'b0);
        idle(4);

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            logic [1:0] rv;
            logic [4:0] ra0, ra1;
            rv  = 2'($urandom_range(0, 3));
            ra0 = ($urandom_range(0, 7) == 0) ? ZREG : 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 7) == 0) ? ZREG : 5'($urandom_range(0, 31));
            step(rv, ra0, ra1, rnd_data(), rnd_data(),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0));
        end
        idle(3);

        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
